// File: rtl/fetch_unit.sv
// fetch_unit - instruction-fetch stage of the 5-stage core.
//
// Owns the PC and issues word fetches to instruction memory over a
// request/grant interface whose responses return in request order. Returned
// words are buffered, tagged with their PC, in a small FIFO that feeds ID.
// A taken branch from EX redirects the PC, empties the FIFO and marks every
// in-flight response for discard.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   ex_taken, ex_target      redirect request and target (bits [1:0] ignored)
//   id_ready                 ID consumes the head instruction this cycle
//   imem_req, imem_addr      fetch request and word-aligned address
//   imem_gnt                 memory accepts the request this cycle
//   imem_rvalid, imem_rdata  in-order response and instruction word
//   if_valid, if_pc,
//   if_instr                 FIFO head presented to ID (NOP and pc 0 when empty)

module fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_taken,
  input  logic [ADDR_WIDTH-1:0] ex_target,
  input  logic                  id_ready,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [31:0]           imem_rdata,
  output logic                  if_valid,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic [31:0]           if_instr
);

  localparam int          PW     = $clog2(DEPTH);
  localparam int          CW     = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CREDIT = (CW+1)'(DEPTH);
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic [ADDR_WIDTH-1:0] pc;
  logic [CW-1:0]         out_cnt;
  logic [CW-1:0]         kill_cnt;
  logic [CW-1:0]         fifo_cnt;
  logic [PW-1:0]         fifo_rd;
  logic [PW-1:0]         fifo_wr;
  logic [PW-1:0]         aq_rd;
  logic [PW-1:0]         aq_wr;

  logic [ADDR_WIDTH-1:0] fifo_pc    [DEPTH];
  logic [31:0]           fifo_instr [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q     [DEPTH];

  logic [CW:0] credit_used;
  logic        grant;
  logic        resp;
  logic        keep;
  logic        pop;
  logic        unused_target_bits;

  // Target is forced word aligned, so its low bits never matter.
  assign unused_target_bits = ^ex_target[1:0];

  // Credit covers both outstanding requests and buffered words, so every
  // response is guaranteed a free FIFO slot when it arrives.
  assign credit_used = {1'b0, out_cnt} + {1'b0, fifo_cnt};
  assign imem_req    = rst_n && !ex_taken && (credit_used < CREDIT);
  assign imem_addr   = pc;
  assign grant       = imem_req && imem_gnt;

  // A response with nothing outstanding is a protocol violation and ignored.
  assign resp = imem_rvalid && (out_cnt != '0);
  assign keep = resp && !ex_taken && (kill_cnt == '0);

  assign if_valid = (fifo_cnt != '0) && !ex_taken;
  assign pop      = if_valid && id_ready;
  assign if_pc    = if_valid ? fifo_pc[fifo_rd] : '0;
  assign if_instr = if_valid ? fifo_instr[fifo_rd] : NOP;

  // Control state. The address queue keeps running through a redirect
  // because discarded requests still return a response that must pop it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      out_cnt  <= '0;
      kill_cnt <= '0;
      fifo_cnt <= '0;
      fifo_rd  <= '0;
      fifo_wr  <= '0;
      aq_rd    <= '0;
      aq_wr    <= '0;
    end else begin
      if (grant) aq_wr <= aq_wr + 1'b1;
      if (resp)  aq_rd <= aq_rd + 1'b1;

      case ({grant, resp})
        2'b10:   out_cnt <= out_cnt + 1'b1;
        2'b01:   out_cnt <= out_cnt - 1'b1;
        default: out_cnt <= out_cnt;
      endcase

      if (ex_taken) begin
        // A response landing in the redirect cycle is already excluded
        // from the kill count because it is dropped right here.
        pc       <= {ex_target[ADDR_WIDTH-1:2], 2'b00};
        kill_cnt <= out_cnt - CW'(resp);
        fifo_cnt <= '0;
        fifo_rd  <= '0;
        fifo_wr  <= '0;
      end else begin
        if (grant) pc <= pc + ADDR_WIDTH'(4);
        if (resp && (kill_cnt != '0)) kill_cnt <= kill_cnt - 1'b1;
        if (keep) fifo_wr <= fifo_wr + 1'b1;
        if (pop)  fifo_rd <= fifo_rd + 1'b1;
        case ({keep, pop})
          2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
          2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
          default: fifo_cnt <= fifo_cnt;
        endcase
      end
    end
  end

  // Storage arrays need no reset; the pointers and counts define validity.
  always_ff @(posedge clk) begin
    if (grant) addr_q[aq_wr] <= pc;
    if (keep) begin
      fifo_pc[fifo_wr]    <= addr_q[aq_rd];
      fifo_instr[fifo_wr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit - self-checking bench for fetch_unit.
//
// A memory model answers granted fetches in order after a chosen latency.
// A queue-based model of the fetch stage (in-flight list with per-entry
// discard flags, buffered PC list, current PC) predicts every output each
// cycle; directed scenarios add literal expectations on top.

module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_taken = 1'b0;
  logic [31:0] ex_target = '0;
  logic        id_ready = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ex_taken(ex_taken), .ex_target(ex_target),
    .id_ready(id_ready), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [31:0] addr; } memRsp_t;
  typedef struct { logic [31:0] addr; bit killed; } flight_t;

  memRsp_t     memQ[$];
  flight_t     mInflight[$];
  logic [31:0] mFifo[$];
  logic [31:0] mPc;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int memLat = 1;
  int lastDue = -1;
  int obsGrants = 0;
  bit memFire = 1'b0;
  bit spurOk = 1'b0;

  function automatic logic [31:0] instrOf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic failBound(input string name);
    checks++;
    fails++;
    $display("[TB] FAIL %s: bound of cycles expired, got no if_valid expected one", name);
  endtask

  // Compare every DUT output against the model for the current cycle.
  task automatic checkOutput();
    bit          eReq;
    bit          eVal;
    logic [31:0] ePc;
    logic [31:0] eIns;
    eReq = !ex_taken && ((mInflight.size() + mFifo.size()) < DEPTH);
    eVal = (mFifo.size() != 0) && !ex_taken;
    ePc  = eVal ? mFifo[0] : 32'h0;
    eIns = eVal ? instrOf(mFifo[0]) : 32'h0000_0013;
    checkVal("imem_req", {31'b0, imem_req}, {31'b0, eReq});
    checkVal("imem_addr", imem_addr, mPc);
    checkVal("if_valid", {31'b0, if_valid}, {31'b0, eVal});
    checkVal("if_pc", if_pc, ePc);
    checkVal("if_instr", if_instr, eIns);
  endtask

  // Drive one cycle's inputs (called just after a rising edge), then
  // move to mid-cycle and check outputs.
  task automatic applyStimulus(input bit taken, input logic [31:0] tgt,
                               input bit ready, input bit gnt);
    ex_taken  = taken;
    ex_target = tgt;
    id_ready  = ready;
    imem_gnt  = gnt;
    memFire   = (memQ.size() != 0) && (memQ[0].due <= cyc);
    if (memFire) begin
      imem_rvalid = 1'b1;
      imem_rdata  = instrOf(memQ[0].addr);
    end else begin
      imem_rvalid = spurOk && (memQ.size() == 0) && ($urandom_range(0, 15) == 0);
      imem_rdata  = $urandom;
    end
    @(negedge clk);
    if (imem_req && imem_gnt) obsGrants++;
    checkOutput();
  endtask

  // Advance the model and memory by the cycle just checked, then step.
  task automatic endCycle();
    bit      eReq;
    bit      eVal;
    bit      rsp;
    flight_t f;
    memRsp_t r;
    eReq = !ex_taken && ((mInflight.size() + mFifo.size()) < DEPTH);
    eVal = (mFifo.size() != 0) && !ex_taken;
    rsp  = imem_rvalid && (mInflight.size() != 0);
    if (memFire) void'(memQ.pop_front());
    if (ex_taken) begin
      if (rsp) void'(mInflight.pop_front());
      for (int i = 0; i < mInflight.size(); i++) mInflight[i].killed = 1'b1;
      mFifo.delete();
      mPc = {ex_target[31:2], 2'b00};
    end else begin
      if (rsp) begin
        f = mInflight.pop_front();
        if (!f.killed) mFifo.push_back(f.addr);
      end
      if (eVal && id_ready) void'(mFifo.pop_front());
      if (eReq && imem_gnt) begin
        f.addr = mPc;
        f.killed = 1'b0;
        mInflight.push_back(f);
        r.due = cyc + memLat;
        if (r.due <= lastDue) r.due = lastDue + 1;
        lastDue = r.due;
        r.addr = mPc;
        memQ.push_back(r);
        mPc = mPc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic runCycle(input bit taken, input logic [31:0] tgt, input bit ready, input bit gnt);
    applyStimulus(taken, tgt, ready, gnt);
    endCycle();
  endtask

  // Asynchronous reset mid-cycle, outputs checked before any clock edge.
  task automatic doReset();
    rst_n       = 1'b0;
    ex_taken    = 1'b0;
    ex_target   = '0;
    id_ready    = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    #1;
    checkVal("rst_imem_req", {31'b0, imem_req}, 32'h0);
    checkVal("rst_if_valid", {31'b0, if_valid}, 32'h0);
    checkVal("rst_if_pc", if_pc, 32'h0);
    checkVal("rst_if_instr", if_instr, 32'h0000_0013);
    checkVal("rst_imem_addr", imem_addr, RESET_PC);
    mInflight.delete();
    mFifo.delete();
    memQ.delete();
    mPc = RESET_PC;
    lastDue = -1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  // Run normal cycles until if_valid, then require the given head PC.
  task automatic waitFirstValid(input string name, input logic [31:0] expPc);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b1);
      if (if_valid) begin
        checkVal(name, if_pc, expPc);
        found = 1'b1;
      end
      endCycle();
      if (found) break;
    end
    if (!found) failBound(name);
  endtask

  initial begin
    @(posedge clk);
    #1;

    // Reset release, 1-cycle memory, ID always ready.
    doReset();
    memLat = 1;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b1);
      if (k < 4) checkVal("startup_addr", imem_addr, 32'(4 * k));
      if (k < 2) checkVal("startup_valid_low", {31'b0, if_valid}, 32'h0);
      else begin
        checkVal("stream_valid", {31'b0, if_valid}, 32'h1);
        checkVal("stream_pc", if_pc, 32'(4 * (k - 2)));
      end
      endCycle();
    end

    // Stall: ID not ready for 10 cycles.
    doReset();
    obsGrants = 0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      if (k >= 2) begin
        checkVal("stall_valid", {31'b0, if_valid}, 32'h1);
        checkVal("stall_head_pc", if_pc, 32'h0);
      end
      endCycle();
    end
    checkVal("stall_grants", 32'(obsGrants), 32'd4);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkVal("stall_req_low", {31'b0, imem_req}, 32'h0);
    endCycle();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b1);
      checkVal("resume_valid", {31'b0, if_valid}, 32'h1);
      checkVal("resume_pc", if_pc, 32'(4 * k));
      endCycle();
    end

    // Redirect with two responses in flight, 3-cycle memory.
    doReset();
    memLat = 3;
    runCycle(1'b0, '0, 1'b1, 1'b1);
    runCycle(1'b0, '0, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h0000_0103, 1'b1, 1'b1);
    checkVal("redir_req_low", {31'b0, imem_req}, 32'h0);
    endCycle();
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    checkVal("redir_addr", imem_addr, 32'h0000_0100);
    endCycle();
    waitFirstValid("redir_first_pc", 32'h0000_0100);

    // Redirect in the same cycle as a response, no grant possible.
    doReset();
    memLat = 2;
    runCycle(1'b0, '0, 1'b1, 1'b1);
    runCycle(1'b0, '0, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h0000_0500, 1'b1, 1'b0);
    checkVal("coinc_valid_low", {31'b0, if_valid}, 32'h0);
    endCycle();
    waitFirstValid("coinc_first_pc", 32'h0000_0500);

    // Back-to-back redirects.
    doReset();
    memLat = 2;
    for (int k = 0; k < 3; k++) runCycle(1'b0, '0, 1'b1, 1'b1);
    runCycle(1'b1, 32'h0000_0200, 1'b1, 1'b1);
    runCycle(1'b1, 32'h0000_0300, 1'b1, 1'b1);
    waitFirstValid("b2b_first_pc", 32'h0000_0300);
    for (int k = 1; k < 4; k++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b1);
      checkVal("b2b_valid", {31'b0, if_valid}, 32'h1);
      checkVal("b2b_pc", if_pc, 32'h0000_0300 + 32'(4 * k));
      endCycle();
    end

    // PC wrap.
    doReset();
    memLat = 1;
    runCycle(1'b0, '0, 1'b1, 1'b1);
    runCycle(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    checkVal("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    endCycle();
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    checkVal("wrap_addr1", imem_addr, 32'h0000_0000);
    endCycle();
    waitFirstValid("wrap_first_pc", 32'hFFFF_FFFC);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    checkVal("wrap_second_pc", if_pc, 32'h0000_0000);
    endCycle();

    // Randomized traffic against the model, with spurious responses,
    // variable latency and occasional mid-run reset.
    doReset();
    spurOk = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) doReset();
      memLat = $urandom_range(1, 3);
      runCycle($urandom_range(0, 15) == 0, $urandom,
               $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 5-stage core. It owns the PC, issues word requests to instruction memory over a request/grant, in-order-response interface, and buffers returned instructions in a small FIFO that feeds ID. It is redirected by the EX-stage branch resolution (`taken` plus target). On redirect it flushes its buffer and discards every in-flight response.

## Interface

- `ADDR_WIDTH`, 32, PC / memory address width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `DEPTH`, 4, instruction FIFO entries; also the credit limit on outstanding requests plus buffered entries (power of 2, ≥2)

- `clk` in 1: the single clock; all state updates on its rising edge
- `rst_n` in 1: reset is asynchronous and active-low
- `ex_taken` in 1: redirect request from EX branch resolution (covers jal/jalr and taken conditional branches)
- `ex_target` in ADDR_WIDTH: redirect address; bits [1:0] ignored and treated as 0
- `id_ready` in 1: ID accepts the head instruction this cycle (low = stall)
- `imem_req` out 1: fetch request valid
- `imem_addr` out ADDR_WIDTH: fetch address, always word aligned
- `imem_gnt` in 1: memory accepts the request this cycle
- `imem_rvalid` in 1: response data valid; responses return in request order, ≥1 cycle after grant
- `imem_rdata` in 32: instruction word
- `if_valid` out 1: FIFO head holds a valid instruction for ID
- `if_pc` out ADDR_WIDTH: PC of the head instruction
- `if_instr` out 32: head instruction

## Operation

- State:
  - `pc` register
  - `out_cnt`: granted, not yet responded (0..DEPTH)
  - `kill_cnt`: in-flight responses to discard (0..DEPTH)
  - FIFO of {pc, instr} with `fifo_cnt`
  - PC FIFO: a queue of granted addresses (DEPTH deep), so each response is tagged with its PC
- Issue:
  - `imem_req = rst_n && !ex_taken && (out_cnt + fifo_cnt < DEPTH)`, using registered counts only.
  - `imem_addr = pc`.
  - Grant (`imem_req && imem_gnt`): `pc <= pc + 4` (wraps modulo 2^ADDR_WIDTH), `out_cnt++`, and the address is queued.
- Response (`imem_rvalid`):
  - `out_cnt--` and the address queue is popped.
  - If `kill_cnt > 0`: `kill_cnt--` and the data is dropped.
  - Otherwise {pc, rdata} is pushed into the FIFO.
  - The credit rule guarantees the FIFO is never full on push.
- Pop: `if_valid && id_ready` removes the head.
- Redirect (`ex_taken = 1`), with priority over all other events in that cycle:
  - `pc <= {ex_target[ADDR_WIDTH-1:2], 2'b00}`.
  - FIFO cleared.
  - `kill_cnt <= out_cnt - imem_rvalid`, so a response arriving this cycle is itself dropped.
  - No request issued; no pop counted.
- Head outputs:
  - `if_valid = (fifo_cnt != 0) && !ex_taken`.
  - When `if_valid = 0`: `if_pc = 0` and `if_instr = 32'h0000_0013` (NOP).
- Spurious `imem_rvalid` with `out_cnt == 0` is a protocol violation; the unit ignores it and counts do not underflow.
- A second `ex_taken` while `kill_cnt > 0` recomputes `kill_cnt` from the current `out_cnt` by the same rule.

## Timing

- Reset (async assert, sync-clean deassert):
  - `pc = RESET_PC`, all counts 0, FIFO empty.
  - `imem_req = 0`, `if_valid = 0`, `if_pc = 0`, `if_instr = 32'h13`.
  - `imem_addr = RESET_PC`.
- First request: `imem_req = 1` in the first cycle with `rst_n` high.
- Latency: grant in cycle N, rvalid in N+1, `if_valid` in N+2 (no bypass from `imem_rdata` to `if_instr`).
- Throughput: with DEPTH=4 and a 1-cycle memory that always grants, one instruction per cycle is sustained while `id_ready = 1`.
- Redirect:
  - `ex_taken` in cycle R: `imem_req = 0` and `if_valid = 0` in R.
  - In R+1, `imem_addr = target` and `imem_req` obeys the credit rule.
  - The first target instruction reaches `if_valid` no earlier than R+3.
- Stall: with `id_ready = 0`, the FIFO fills and then `imem_req` drops once `out_cnt + fifo_cnt = DEPTH`. No data is lost, and no request is issued beyond credit.
- Mid-operation reset: all state is cleared immediately. Memory is reset in the same domain, so no stale responses are expected.

## Test plan

- Reset release with a 1-cycle memory that always grants and `id_ready = 1`: the PC sequence is 0, 4, 8, 0xC; `if_valid` first rises 2 cycles after the first grant; then one instruction per cycle.
- Stall: hold `id_ready = 0` for 10 cycles. Required: exactly 4 grants occur, `imem_req` is 0 afterwards, and the head stays at pc 0 (`if_valid = 1`, `if_pc = 0` throughout). On release, instructions resume in order with no gaps and no duplicates.
- Redirect with 2 in flight: use a 3-cycle memory latency and assert `ex_taken` with `ex_target = 0x103` while `out_cnt = 2`. Required:
  - both late responses are dropped;
  - the next `imem_addr` is 0x100;
  - the first `if_pc` after redirect is 0x100.
- Redirect coinciding with `imem_rvalid`, with no grant possible that cycle: that response is dropped, `kill_cnt = out_cnt - 1`, and no instruction from the old path reaches `if_valid`.
- Back-to-back redirects to 0x200 then 0x300 (cycles R and R+1): only 0x300-path instructions appear, and `kill_cnt` returns to 0.
- PC wrap: `ex_target = 0xFFFF_FFFC`. Required: the fetched PCs are 0xFFFF_FFFC then 0x0000_0000.
